// File: rtl/regfile_dump_unit_if.sv
// Dump-unit bus: RegisterFile read port plus the valid/ready dump stream.
// The master side is the dump unit; the slave side is the register file and the consumer.
interface regfile_dump_unit_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] rfReadAddr;
   logic [DATA_WIDTH-1:0] rfReadData;
   logic                  dumpValid;
   logic                  dumpReady;
   logic [DATA_WIDTH-1:0] dumpData;
   logic [ADDR_WIDTH:0]   dumpIndex;

   modport master (
      output rfReadAddr,
      input  rfReadData,
      output dumpValid,
      input  dumpReady,
      output dumpData,
      output dumpIndex
   );

   modport slave (
      input  rfReadAddr,
      output rfReadData,
      input  dumpValid,
      output dumpReady,
      input  dumpData,
      input  dumpIndex
   );
endinterface

// File: rtl/regfile_dump_unit.sv
// Walks x0..x(REG_NUM-1) through one RegisterFile read port and streams each value out.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word (dumpIndex == REG_NUM).
module regfile_dump_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_NUM    = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   regfile_dump_unit_if.master bus,
   output logic                busy,
   output logic                done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {StIdle, StRead, StSend, StCsum, StDone} state_e;
`else
   typedef enum logic [2:0] {StIdle, StRead, StSend, StDone} state_e;
`endif

   localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(REG_NUM - 1);
   localparam logic [ADDR_WIDTH-1:0] IdxOne  = ADDR_WIDTH'(1);

   state_e                stateQ, stateD;
   logic [ADDR_WIDTH-1:0] idxQ, idxD;
   logic [DATA_WIDTH-1:0] dataQ, dataD;
   logic [ADDR_WIDTH:0]   indexQ, indexD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   localparam logic [ADDR_WIDTH:0] CsumIdx = (ADDR_WIDTH + 1)'(REG_NUM);
   logic [DATA_WIDTH-1:0] checksumQ, checksumD;
`endif

   always_comb begin
      stateD = stateQ;
      idxD   = idxQ;
      dataD  = dataQ;
      indexD = indexQ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      checksumD = checksumQ;
`endif
      unique case (stateQ)
         StIdle: begin
            if (start) begin
               stateD = StRead;
               idxD   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
               checksumD = '0;
`endif
            end
         end
         StRead: begin
            dataD  = bus.rfReadData;
            indexD = {1'b0, idxQ};
            stateD = StSend;
         end
         StSend: begin
            if (bus.dumpReady) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
               checksumD = checksumQ ^ dataQ;
`endif
               if (idxQ == LastIdx) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  // Checksum word reuses the output register so dumpData stays registered.
                  stateD = StCsum;
                  dataD  = checksumQ ^ dataQ;
                  indexD = CsumIdx;
`else
                  stateD = StDone;
`endif
               end else begin
                  idxD   = idxQ + IdxOne;
                  stateD = StRead;
               end
            end
         end
`ifdef REGFILE_DUMP_CHECKSUM_EN
         StCsum: begin
            if (bus.dumpReady) stateD = StDone;
         end
`endif
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ <= StIdle;
         idxQ   <= '0;
         dataQ  <= '0;
         indexQ <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
         checksumQ <= '0;
`endif
      end else begin
         stateQ <= stateD;
         idxQ   <= idxD;
         dataQ  <= dataD;
         indexQ <= indexD;
`ifdef REGFILE_DUMP_CHECKSUM_EN
         checksumQ <= checksumD;
`endif
      end
   end

   // Read address follows idx directly, so it holds the last index outside READ.
   assign bus.rfReadAddr = idxQ;
   assign bus.dumpData   = dataQ;
   assign bus.dumpIndex  = indexQ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   assign bus.dumpValid  = (stateQ == StSend) || (stateQ == StCsum);
`else
   assign bus.dumpValid  = (stateQ == StSend);
`endif
   assign busy = (stateQ != StIdle);
   assign done = (stateQ == StDone);

endmodule
